// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: soft-start/stop duty sequencer with period-aligned PWM.
// Optional 7-seg level display built when PWM_CTRL_DISPLAY_EN is defined.
module pwm_duty_ctrl #(
  parameter int SLOT_CYCLES = 1000,
  parameter int RAMP_CYCLES = 50000,
  parameter int START_LEVEL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swt_start_stop,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  output logic       motor_pwm,
  output logic       motor_running,
  output logic [3:0] duty_level,
  output logic       ramping,
  output logic [6:0] display
);
  localparam int PW = $clog2(SLOT_CYCLES + 1);
  localparam int RW = $clog2(RAMP_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(SLOT_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(RAMP_CYCLES - 1);
  localparam logic [3:0] START = 4'(START_LEVEL);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } state_t;

  state_t state, state_nx;

  logic          ss_q, inc_q, dec_q;
  logic          inc_p, dec_p;
  logic          inc_edge, dec_edge;
  logic          tick;
  logic [RW-1:0] ramp_cnt;
  logic [3:0]    level_nx;
  logic [PW-1:0] presc;
  logic [3:0]    phase;
  logic [3:0]    applied_duty;

  assign inc_edge = inc_q & ~inc_p;
  assign dec_edge = dec_q & ~dec_p;
  assign tick     = (ramp_cnt == RMAX);

  always_comb begin
    state_nx = state;
    level_nx = duty_level;
    unique case (state)
      IDLE: begin
        level_nx = '0;
        if (ss_q) state_nx = RAMP_UP;
      end
      RAMP_UP: begin
        if (!ss_q)
          state_nx = RAMP_DOWN;
        else if (duty_level >= START)
          state_nx = RUN;
        else if (tick)
          level_nx = duty_level + 4'd1;
      end
      RUN: begin
        if (!ss_q) begin
          state_nx = RAMP_DOWN;
        end else if (inc_edge && !dec_edge) begin
          if (duty_level < 4'd9)
            level_nx = duty_level + 4'd1;
        end else if (dec_edge && !inc_edge) begin
          if (duty_level > 4'd1)
            level_nx = duty_level - 4'd1;
        end
      end
      RAMP_DOWN: begin
        if (ss_q)
          state_nx = RAMP_UP;
        else if (duty_level == 4'd0)
          state_nx = IDLE;
        else if (tick)
          level_nx = duty_level - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ss_q          <= 1'b0;
      inc_q         <= 1'b0;
      dec_q         <= 1'b0;
      inc_p         <= 1'b0;
      dec_p         <= 1'b0;
      duty_level    <= '0;
      ramp_cnt      <= '0;
      motor_running <= 1'b0;
      ramping       <= 1'b0;
    end else begin
      state         <= state_nx;
      ss_q          <= swt_start_stop;
      inc_q         <= swt_increase;
      dec_q         <= swt_decrease;
      inc_p         <= inc_q;
      dec_p         <= dec_q;
      duty_level    <= level_nx;
      motor_running <= (state_nx != IDLE);
      ramping       <= (state_nx == RAMP_UP) ||
                       (state_nx == RAMP_DOWN);
      // Any state change restarts the ramp interval
      if ((state_nx != state) || tick)
        ramp_cnt <= '0;
      else
        ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      phase        <= '0;
      applied_duty <= '0;
      motor_pwm    <= 1'b0;
    end else begin
      if (presc == PMAX) begin
        presc <= '0;
        phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      // Duty only changes at period start to avoid glitches
      if ((phase == 4'd0) && (presc == '0))
        applied_duty <= duty_level;
      motor_pwm <= (phase < applied_duty);
    end
  end

`ifdef PWM_CTRL_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      display <= 7'b1000000;
    end else begin
      case (duty_level)
        4'd0:    display <= 7'b1000000;
        4'd1:    display <= 7'b1111001;
        4'd2:    display <= 7'b0100100;
        4'd3:    display <= 7'b0110000;
        4'd4:    display <= 7'b0011001;
        4'd5:    display <= 7'b0010010;
        4'd6:    display <= 7'b0000010;
        4'd7:    display <= 7'b1111000;
        4'd8:    display <= 7'b0000000;
        4'd9:    display <= 7'b0010000;
        default: display <= 7'b1111111;
      endcase
    end
  end
`else
  assign display = 7'b1111111;
`endif

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed bench for pwm_duty_ctrl.
// SLOT_CYCLES=2, RAMP_CYCLES=4, START_LEVEL=5.
module tb_pwm_duty_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       inc;
  logic       dec;
  logic       motor_pwm;
  logic       motor_running;
  logic [3:0] duty_level;
  logic       ramping;
  logic [6:0] display;

  int n_cmp = 0;
  int n_bad = 0;
  int hi;

  pwm_duty_ctrl #(
    .SLOT_CYCLES(2),
    .RAMP_CYCLES(4),
    .START_LEVEL(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .swt_start_stop(ss),
    .swt_increase  (inc),
    .swt_decrease  (dec),
    .motor_pwm     (motor_pwm),
    .motor_running (motor_running),
    .duty_level    (duty_level),
    .ramping       (ramping),
    .display       (display)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(int l);
`ifdef PWM_CTRL_DISPLAY_EN
    case (l)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
`else
    return 7'b1111111;
`endif
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hi_count(output int h);
    h = 0;
    repeat (20) begin
      step(1);
      h += int'(motor_pwm);
    end
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    step(2);
    inc = 1'b0;
    step(2);
  endtask

  task automatic pulse_dec();
    dec = 1'b1;
    step(2);
    dec = 1'b0;
    step(2);
  endtask

  initial begin
    rst = 1'b1;
    ss  = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    step(2);
    chk("rst_duty", 32'(duty_level), 0);
    chk("rst_pwm", 32'(motor_pwm), 0);
    chk("rst_run", 32'(motor_running), 0);
    chk("rst_ramp", 32'(ramping), 0);
    chk("rst_disp", 32'(display), 32'(seg(0)));

    // soft start
    rst = 1'b0;
    ss  = 1'b1;
    step(1);
    chk("ss_lat1", 32'(motor_running), 0);
    step(1);
    chk("ss_run", 32'(motor_running), 1);
    chk("ss_ramp", 32'(ramping), 1);
    step(3);
    chk("ss_pre1", 32'(duty_level), 0);
    step(1);
    chk("ss_l1", 32'(duty_level), 1);
    for (int k = 2; k <= 5; k++) begin
      step(4);
      chk($sformatf("ss_l%0d", k), 32'(duty_level), 32'(k));
    end
    chk("ss_ramp5", 32'(ramping), 1);
    step(1);
    chk("ss_runst", 32'(ramping), 0);
    step(22);
    hi_count(hi);
    chk("ss_hi5", 32'(hi), 10);
    chk("ss_disp5", 32'(display), 32'(seg(5)));

    // adjust in RUN
    inc = 1'b1;
    step(1);
    chk("inc_lat1", 32'(duty_level), 5);
    step(1);
    chk("inc_lat2", 32'(duty_level), 6);
    inc = 1'b0;
    step(2);
    for (int k = 0; k < 5; k++) pulse_inc();
    chk("inc_sat", 32'(duty_level), 9);
    step(22);
    hi_count(hi);
    chk("inc_hi9", 32'(hi), 18);
    chk("inc_disp9", 32'(display), 32'(seg(9)));
    for (int k = 0; k < 9; k++) pulse_dec();
    chk("dec_sat", 32'(duty_level), 1);
    step(22);
    hi_count(hi);
    chk("dec_hi1", 32'(hi), 2);
    chk("dec_disp1", 32'(display), 32'(seg(1)));

    // simultaneous edges
    for (int k = 0; k < 4; k++) pulse_inc();
    chk("sim_pre", 32'(duty_level), 5);
    inc = 1'b1;
    dec = 1'b1;
    step(2);
    chk("sim_edge", 32'(duty_level), 5);
    step(10);
    chk("sim_hold", 32'(duty_level), 5);
    inc = 1'b0;
    dec = 1'b0;
    step(2);

    // soft stop from 7
    pulse_inc();
    pulse_inc();
    chk("stop_pre", 32'(duty_level), 7);
    ss = 1'b0;
    step(2);
    chk("stop_ramp", 32'(ramping), 1);
    for (int k = 6; k >= 0; k--) begin
      step(4);
      chk($sformatf("stop_l%0d", k), 32'(duty_level), 32'(k));
    end
    step(1);
    chk("stop_idle", 32'(motor_running), 0);
    chk("stop_rampo", 32'(ramping), 0);
    step(22);
    hi_count(hi);
    chk("stop_hi0", 32'(hi), 0);

    // reversal during RAMP_UP at level 2
    ss = 1'b1;
    step(10);
    chk("revu_l2", 32'(duty_level), 2);
    ss = 1'b0;
    step(2);
    chk("revu_ramp", 32'(ramping), 1);
    step(4);
    chk("revu_l1", 32'(duty_level), 1);
    step(4);
    chk("revu_l0", 32'(duty_level), 0);
    step(1);
    chk("revu_idle", 32'(motor_running), 0);

    // reversal during RAMP_DOWN at level 3
    ss = 1'b1;
    step(23);
    chk("revd_run", 32'(ramping), 0);
    chk("revd_l5", 32'(duty_level), 5);
    ss = 1'b0;
    step(10);
    chk("revd_l3", 32'(duty_level), 3);
    ss = 1'b1;
    step(6);
    chk("revd_l4", 32'(duty_level), 4);
    step(4);
    chk("revd_l5b", 32'(duty_level), 5);
    step(1);
    chk("revd_runst", 32'(ramping), 0);
    chk("revd_running", 32'(motor_running), 1);

    // reset mid-RUN at level 8
    for (int k = 0; k < 3; k++) pulse_inc();
    chk("rr_l8", 32'(duty_level), 8);
    rst = 1'b1;
    ss  = 1'b0;
    step(1);
    chk("rr_duty", 32'(duty_level), 0);
    chk("rr_pwm", 32'(motor_pwm), 0);
    chk("rr_run", 32'(motor_running), 0);
    chk("rr_ramp", 32'(ramping), 0);
    chk("rr_disp", 32'(display), 32'(seg(0)));
    rst = 1'b0;
    pulse_inc();
    pulse_inc();
    chk("idle_inc", 32'(duty_level), 0);
    chk("idle_run", 32'(motor_running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Duty-cycle controller for the motor PWM path. Converts the operator switches (start/stop level, increase/decrease buttons) into a sequenced duty level 0–9 with soft-start and soft-stop ramps. Generates the motor PWM waveform with glitch-free, period-aligned duty updates. Optionally drives a 7-segment digit showing the current level; sits between the switch inputs and the motor driver pin.

## Interface
- `SLOT_CYCLES`, default 1000: clocks per PWM slot. One PWM period = 10 slots. Must be ≥1.
- `RAMP_CYCLES`, default 50000: clocks between level steps while ramping. Must be ≥1.
- `START_LEVEL`, default 5: soft-start target level, range 1–9.
- `clk`, input, 1: sole clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `swt_start_stop`, input, 1: level; 1 = run request, 0 = stop request.
- `swt_increase`, input, 1: level; each rising edge is one increment request.
- `swt_decrease`, input, 1: level; each rising edge is one decrement request.
- `motor_pwm`, output, 1: registered PWM drive.
- `motor_running`, output, 1: 1 whenever the FSM is not in IDLE.
- `duty_level`, output, 4: current target level, 0–9.
- `ramping`, output, 1: 1 in RAMP_UP or RAMP_DOWN.
- `display`, output, 7: active-low 7-segment code, bit order gfedcba.

## Operation
- Inputs `swt_*` are registered once. A rising edge is (current sample = 1 && previous sample = 0).
- **FSM states:** IDLE, RAMP_UP, RUN, RAMP_DOWN.
  - IDLE: level = 0. If `swt_start_stop` = 1, go to RAMP_UP.
  - RAMP_UP:
    - If `swt_start_stop` = 0, go to RAMP_DOWN (highest priority).
    - Else if level ≥ START_LEVEL, go to RUN.
    - Else on each ramp tick, level += 1.
  - RUN:
    - If `swt_start_stop` = 0, go to RAMP_DOWN.
    - An increase edge alone sets level = min(level+1, 9).
    - A decrease edge alone sets level = max(level−1, 1).
    - Increase and decrease edges in the same cycle are ignored, and level holds.
  - RAMP_DOWN:
    - If `swt_start_stop` = 1, go to RAMP_UP.
    - Else if level = 0, go to IDLE.
    - Else on each ramp tick, level −= 1.
- Increase/decrease edges outside RUN are discarded, not queued.
- **Ramp tick:** the ramp counter clears on every state change. It counts 0..RAMP_CYCLES−1, and a tick fires when the count = RAMP_CYCLES−1, after which the counter wraps to 0.
- **PWM generation:**
  - The slot prescaler counts 0..SLOT_CYCLES−1.
  - The phase counter advances 0..9 when the prescaler wraps.
  - `applied_duty` loads from `duty_level` only when phase = 0 and prescaler = 0, which is the period start.
  - `motor_pwm` <= (phase < applied_duty), so duty is applied_duty × 10 %.
  - Level 0 gives constant low; level 9 gives 90 %.
- The PWM counters run freely in all states. Level-change arithmetic is 4-bit, saturating at both ends; no wrap is possible.

## Timing
- **Reset values** (rst sampled high):
  - state = IDLE
  - `duty_level` = 0, `applied_duty` = 0
  - all counters = 0
  - `motor_pwm` = 0, `motor_running` = 0, `ramping` = 0
  - `display` = 7'b1000000 with the macro defined, 7'b1111111 without it
- Reset asserted mid-ramp or mid-run takes effect on that edge, with no ramp-down.
- Switch-to-state latency: 2 clocks (input register, then state register).
- A RUN increase/decrease edge reaches `duty_level` 2 clocks after the input rises.
- `duty_level` to `motor_pwm` change happens at the next period start + 1 clock (registered output). Worst case is 10·SLOT_CYCLES + 1 clocks.
- `motor_running` and `ramping` are registered decodes of state. They update in the same cycle as the state register.

## Configuration
- `PWM_CTRL_DISPLAY_EN` defined: `display` is a registered decode of `duty_level`, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - The decode lags `duty_level` by 1 clock.
- `PWM_CTRL_DISPLAY_EN` undefined: the decoder is not built and `display` is tied to 7'b1111111 (all segments off).

## Test plan
Parameters: SLOT_CYCLES = 2, RAMP_CYCLES = 4, START_LEVEL = 5, macro defined.

- **Soft start:** hold start_stop = 1 from reset release.
  - Expect `duty_level` steps 1, 2, 3, 4, 5 at 4-clock intervals, then RUN.
  - Expect `ramping` = 0 afterwards.
  - Expect the steady PWM period to be 20 clocks with 10 clocks high.
  - Expect `display` = 0010010.
- **Adjust in RUN:** starting from level 5, pulse increase 6 times, then decrease 9 times.
  - Expect level to saturate at 9 (PWM high 18 of 20 clocks).
  - Expect level to then saturate at 1 (high 2 of 20 clocks).
- **Simultaneous edges:** at level 5, raise increase and decrease on the same clock.
  - Expect level to stay 5.
  - Then hold both high for 10 clocks; expect no further change.
- **Soft stop:** at level 7, drop start_stop.
  - Expect level 6..0 at 4-clock intervals, then IDLE.
  - Expect `motor_running` = 0 and `motor_pwm` = 0 from the next period start + 1 onward.
- **Reversal mid-ramp:** drop start_stop during RAMP_DOWN at level 3, and raise it again.
  - Expect RAMP_UP with levels 4, 5, then RUN.
  - Also drop start_stop during RAMP_UP at level 2; expect RAMP_DOWN to 0.
- **Reset mid-operation:** assert rst for 1 clock while in RUN at level 8.
  - Next edge: all outputs reach their reset values, `display` = 1000000.
  - Increase pulses during IDLE leave level at 0.
